// File: rtl/ship_placer_if.sv
// ship_placer_if: groups the game-side signals of the ship placement stage.
//   master : drives the placing-phase controls and the cursor/orientation/count inputs,
//            and observes the placement results.
//   slave  : the placer itself. It receives the controls and drives ships_placed,
//            finished_placing, board, place_ok, place_err and busy.
// board bit (i*BOARD_N + j) = 1 means cell (row i, column j) is occupied.
interface ship_placer_if #(
  parameter int BOARD_N = 5
);
  logic                         placing_ships;
  logic                         player_place_ship;
  logic                         orient;
  logic [2:0]                   i_actual;
  logic [2:0]                   j_actual;
  logic [2:0]                   amount_of_ships;
  logic [2:0]                   ships_placed;
  logic                         finished_placing;
  logic [BOARD_N*BOARD_N-1:0]   board;
  logic                         place_ok;
  logic                         place_err;
  logic                         busy;

  modport master (
    output placing_ships, player_place_ship, orient, i_actual, j_actual, amount_of_ships,
    input  ships_placed, finished_placing, board, place_ok, place_err, busy
  );

  modport slave (
    input  placing_ships, player_place_ship, orient, i_actual, j_actual, amount_of_ships,
    output ships_placed, finished_placing, board, place_ok, place_err, busy
  );
endinterface

// File: rtl/ship_placer.sv
// ship_placer: builds the player's ship occupancy map during the placing phase.
// Ship n is n cells long and is anchored at the cursor. Each request is checked one
// cell per cycle for bounds and overlap, then all cells are committed in one cycle.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - ship_placer_if.slave: placing_ships, player_place_ship, orient, i_actual,
//          j_actual, amount_of_ships in; ships_placed, finished_placing, board,
//          place_ok, place_err, busy out
module ship_placer #(
  parameter int BOARD_N   = 5,
  parameter int MAX_SHIPS = 5
) (
  input  logic          clk,
  input  logic          rst,
  ship_placer_if.slave  bus
);
  localparam int NCELL = BOARD_N * BOARD_N;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CHECK, S_COMMIT, S_DONE} state_t;

  state_t             state, state_nx;
  logic               prev_q, req_q;
  logic [2:0]         target_q;
  logic               target_set_q;
  logic [2:0]         i_q, j_q, len_q, k_q;
  logic               orient_q;
  logic [NCELL-1:0]   board_q;
  logic [2:0]         count_q;

  logic               do_latch, do_step, do_commit, ok_pulse, err_pulse;
  logic [3:0]         cur_r, cur_c;
  logic               cell_bad;
  logic [NCELL-1:0]   commit_mask;
  logic [2:0]         amt_clamped;

  // One-hot mask of cell (r, c); empty when the cell is off the board.
  function automatic logic [NCELL-1:0] cell_mask(input logic [3:0] r, input logic [3:0] c);
    cell_mask = '0;
    if (int'(r) < BOARD_N && int'(c) < BOARD_N)
      cell_mask = NCELL'(1) << (int'(r) * BOARD_N + int'(c));
  endfunction

  // Cell under test: 4-bit sums so a 7+4 coordinate cannot wrap back onto the board.
  assign cur_r    = {1'b0, i_q} + (orient_q ? {1'b0, k_q} : 4'd0);
  assign cur_c    = {1'b0, j_q} + (orient_q ? 4'd0 : {1'b0, k_q});
  assign cell_bad = (int'(cur_r) >= BOARD_N) || (int'(cur_c) >= BOARD_N) ||
                    (|(board_q & cell_mask(cur_r, cur_c)));

  // All cells of the ship being committed; every one of them already passed CHECK.
  always_comb begin
    commit_mask = '0;
    for (int k = 0; k < MAX_SHIPS; k++) begin
      if (k < int'(len_q))
        commit_mask = commit_mask |
                      cell_mask({1'b0, i_q} + (orient_q ? 4'(k) : 4'd0),
                                {1'b0, j_q} + (orient_q ? 4'd0 : 4'(k)));
    end
  end

  always_comb begin
    if (bus.amount_of_ships == 3'd0)
      amt_clamped = 3'd1;
    else if (int'(bus.amount_of_ships) > MAX_SHIPS)
      amt_clamped = 3'(MAX_SHIPS);
    else
      amt_clamped = bus.amount_of_ships;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    do_latch  = 1'b0;
    do_step   = 1'b0;
    do_commit = 1'b0;
    ok_pulse  = 1'b0;
    err_pulse = 1'b0;
    case (state)
      S_IDLE:   if (bus.placing_ships) state_nx = S_WAIT;
      S_WAIT: begin
        if (!bus.placing_ships) state_nx = S_IDLE;
        else if (req_q) begin
          do_latch = 1'b1;
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!bus.placing_ships) state_nx = S_IDLE;
        else if (cell_bad) begin
          err_pulse = 1'b1;
          state_nx  = S_WAIT;
        end else if (k_q == len_q - 3'd1) state_nx = S_COMMIT;
        else do_step = 1'b1;
      end
      S_COMMIT: begin
        if (!bus.placing_ships) state_nx = S_IDLE;
        else begin
          ok_pulse  = 1'b1;
          do_commit = 1'b1;
          state_nx  = (count_q + 3'd1 == target_q) ? S_DONE : S_WAIT;
        end
      end
      S_DONE:   state_nx = S_DONE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= 1'b0;
      req_q        <= 1'b0;
      target_q     <= 3'd1;
      target_set_q <= 1'b0;
      i_q          <= '0;
      j_q          <= '0;
      len_q        <= '0;
      k_q          <= '0;
      orient_q     <= 1'b0;
      // NOTE: the board map is real game state that must read empty after reset,
      // so unlike a scratch memory it is cleared here.
      board_q      <= '0;
      count_q      <= '0;
    end else begin
      prev_q <= bus.player_place_ship;
      req_q  <= bus.player_place_ship & ~prev_q;
      // Target is taken once per reset, the first time the placing phase is seen.
      if (state == S_IDLE && bus.placing_ships && !target_set_q) begin
        target_q     <= amt_clamped;
        target_set_q <= 1'b1;
      end
      if (do_latch) begin
        i_q      <= bus.i_actual;
        j_q      <= bus.j_actual;
        orient_q <= bus.orient;
        len_q    <= count_q + 3'd1;
        k_q      <= '0;
      end else if (do_step) begin
        k_q <= k_q + 3'd1;
      end
      if (do_commit) begin
        board_q <= board_q | commit_mask;
        count_q <= count_q + 3'd1;
      end
    end
  end

  assign bus.board            = board_q;
  assign bus.ships_placed     = count_q;
  assign bus.finished_placing = (state == S_DONE);
  assign bus.busy             = (state == S_CHECK) || (state == S_COMMIT);
  assign bus.place_ok         = ok_pulse;
  assign bus.place_err        = err_pulse;
endmodule

// File: doc/ship_placer.md
Name: ship_placer

Overview:
- Placement stage feeding the game FSM during its ship-placing phase.
- Takes the player's cursor cell, orientation and place button, and builds the player's 5x5 ship occupancy map.
- Ship n is n cells long (n = 1..5), anchored at the cursor; every placement is checked for bounds and overlap before commit.
- Produces the placed-ship count (drives the seven-segment decoder) and the finished_placing flag consumed by the FSM.

Parameters:
BOARD_N, 5, board edge length; cells indexed 0..BOARD_N-1 on each axis
MAX_SHIPS, 5, upper clamp on requested ship count and on ship length

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
placing_ships  in  1  FSM state flag; block accepts requests only while high
player_place_ship  in  1  place switch/button level; rising edge = one request
orient  in  1  0 = horizontal (j increases), 1 = vertical (i increases)
i_actual  in  3  cursor row
j_actual  in  3  cursor column
amount_of_ships  in  3  requested ship count
ships_placed  out  3  ships committed so far
finished_placing  out  1  high once ships_placed equals target count
board  out  25  occupancy map; bit (i*5+j) = 1 means cell occupied
place_ok  out  1  one-cycle pulse on successful commit
place_err  out  1  one-cycle pulse on rejected request
busy  out  1  high in CHECK and COMMIT

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- Reset: all outputs 0, board cleared, state IDLE, edge-detect register 0, target 1.
- Edge detect: request = player_place_ship & ~prev, registered on clk. A held level produces exactly one request.
- Target: clamp(amount_of_ships, 1, MAX_SHIPS). Latched in IDLE on the cycle placing_ships is first seen high. Later changes to amount_of_ships are ignored until the next reset.
- States:
  - IDLE: wait for placing_ships = 1 -> WAIT.
  - WAIT: on request, latch i_actual, j_actual and orient, set len = ships_placed+1, k = 0 -> CHECK. Requests in any other state are dropped.
  - CHECK: one cell per cycle. Cell is (i+k, j) if vertical, (i, j+k) if horizontal.
    - Any coordinate > BOARD_N-1, or the cell already set in board: pulse place_err -> WAIT.
    - Else if k = len-1 -> COMMIT; otherwise k++.
  - COMMIT: OR all len cells into board in one cycle; pulse place_ok; increment ships_placed. If the new count equals target -> DONE, else -> WAIT.
  - DONE: finished_placing = 1 (registered, asserted the cycle after the final commit); all requests ignored; held until rst.
- Latency: request edge registered at cycle t; CHECK spans t+1 .. t+len; COMMIT at t+len+1. board and ships_placed show the new value from t+len+2. Error pulses on the failing CHECK cycle.
- Width rules:
  - Coordinate sums use 4-bit arithmetic, so no wrap-around masks an out-of-bounds cell.
  - ships_placed never exceeds target.
- placing_ships falls in WAIT/CHECK/COMMIT: abort to IDLE with no commit and no pulses. board and ships_placed are retained. Re-entry resumes with the same target.
- A request arriving on the same cycle placing_ships rises is ignored; it is only accepted in WAIT.
- rst overrides everything, including mid-CHECK.

Test Plan:
- rst, placing_ships=1, amount=3, request at (0,0) horizontal -> place_ok after 2 cycles (len 1), board bit0=1, ships_placed=1.
- Second ship at (0,3) horizontal, len 2 -> cells (0,3),(0,4) set, board = 0x19, ships_placed=2. Third ship at (2,2) vertical, len 3 -> bits 12,17,22 set; finished_placing=1 the next cycle; further requests leave board unchanged.
- After one ship at (0,0), request len 2 at (0,4) horizontal -> place_err on 2nd CHECK cycle (j=5 out of bounds); board and count unchanged.
- Ship at (1,1) len 1, then len-2 request at (0,1) vertical -> place_err (overlap at (1,1)); a retry at (3,3) vertical succeeds.
- amount=7 -> target clamps to 5; amount=0 -> target 1. Holding player_place_ship high for 20 cycles -> exactly one request; placing_ships dropped mid-CHECK -> no commit, no pulse.
- Reset asserted mid-CHECK -> next cycle board=0, ships_placed=0, finished_placing=0, busy=0.
